microseq_ctrl: RTL and testbench

// - Microprogram sequencer for the core's control store: owns the micro-PC fed to the microcode ROM address (reg_out).
// - Each cycle it consumes the ROM word fields {BT, condition, jump_addr} and selects the next micro-address.
// - Sequences fetch/dispatch/execute for one matrix-multiply core.
// - Provides run/stall/halt control toward the core's top-level controller.

---
 rtl/microseq_ctrl.sv | 123 ++++++++++++
 tb/tb_microseq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/microseq_ctrl.sv
// Microprogram sequencer: owns the micro-PC that addresses the control-store ROM.
// Optional single-step control is enabled by defining MICROSEQ_SINGLE_STEP_EN.
module microseq_ctrl #(
  parameter int UPC_W      = 16,
  parameter int JMP_W      = 7,
  parameter int UCODE_LAST = 74,
  parameter int FETCH_ADDR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             z_flag,
  input  logic [JMP_W-1:0] opcode,
  input  logic             bt,
  input  logic [1:0]       condition,
  input  logic [JMP_W-1:0] jump_addr,
`ifdef MICROSEQ_SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic [UPC_W-1:0] reg_out,
  output logic             ops_valid,
  output logic             busy,
  output logic             halted,
  output logic             fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [UPC_W-1:0] FETCH_UPC = UPC_W'(FETCH_ADDR);
  localparam logic [UPC_W-1:0] LAST_UPC  = UPC_W'(UCODE_LAST);

  state_t           state_reg, state_next;
  logic [UPC_W-1:0] upc_reg, upc_next;
  logic             fault_reg, fault_next;
  logic             step_en;
  logic             advance;
  logic             halt_req;
  logic [UPC_W-1:0] target;
  logic [UPC_W-1:0] upc_inc;

`ifdef MICROSEQ_SINGLE_STEP_EN
  assign step_en = step;
`else
  assign step_en = 1'b1;
`endif

  assign advance = step_en & ~stall;
  assign upc_inc = upc_reg + UPC_W'(1);

  // Target selection: dispatch overrides the condition field entirely.
  always_comb begin
    target   = upc_reg;
    halt_req = 1'b0;
    if (bt) begin
      target = UPC_W'(opcode);
    end else begin
      case (condition)
        2'b00:   target = UPC_W'(jump_addr);
        2'b01:   target = z_flag ? UPC_W'(jump_addr) : upc_inc;
        2'b10:   target = z_flag ? upc_inc : UPC_W'(jump_addr);
        default: halt_req = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    upc_next   = upc_reg;
    fault_next = fault_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          upc_next   = FETCH_UPC;
        end
      end
      ST_RUN: begin
        if (advance) begin
          if (halt_req) begin
            state_next = ST_HALT;
          end else if (target > LAST_UPC) begin
            // Illegal target: freeze the micro-PC where the fault was seen.
            state_next = ST_HALT;
            fault_next = 1'b1;
          end else begin
            upc_next = target;
          end
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
        upc_next   = FETCH_UPC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      upc_reg   <= FETCH_UPC;
      fault_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      upc_reg   <= upc_next;
      fault_reg <= fault_next;
    end
  end

  assign reg_out   = upc_reg;
  assign busy      = (state_reg == ST_RUN);
  assign halted    = (state_reg == ST_HALT);
  assign fault     = fault_reg;
  assign ops_valid = busy & advance;

endmodule

// File: tb/tb_microseq_ctrl.sv
// Directed self-checking bench for the micro-sequencer.
// Each task drives one scenario and checks against hand-computed values.
module tb_microseq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        z_flag = 1'b0;
  logic [6:0]  opcode = '0;
  logic        bt = 1'b0;
  logic [1:0]  condition = '0;
  logic [6:0]  jump_addr = '0;
`ifdef MICROSEQ_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif
  logic [15:0] reg_out;
  logic        ops_valid;
  logic        busy;
  logic        halted;
  logic        fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  microseq_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .z_flag    (z_flag),
    .opcode    (opcode),
    .bt        (bt),
    .condition (condition),
    .jump_addr (jump_addr),
`ifdef MICROSEQ_SINGLE_STEP_EN
    .step      (step),
`endif
    .reg_out   (reg_out),
    .ops_valid (ops_valid),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; z_flag = 0; opcode = '0;
    bt = 0; condition = 2'b00; jump_addr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; start = 1; stall = 1;
    tick();
    reset = 0; start = 0;
    checks++;
    if ({reg_out, ops_valid, busy, halted, fault} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: got reg_out=%0d ov=%b busy=%b halted=%b fault=%b, want all 0",
               reg_out, ops_valid, busy, halted, fault);
    end
    tick();
    stall = 0;
    checks++;
    if (busy !== 1'b0 || reg_out !== 16'd0) begin
      errors++;
      $display("FAIL idle_hold: got busy=%b reg_out=%0d, want busy=0 reg_out=0", busy, reg_out);
    end
    $display("test_reset done");
  endtask

  task automatic test_start_jump();
    do_reset();
    do_start();
    checks++;
    if (reg_out !== 16'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_fetch: got reg_out=%0d busy=%b, want 0 and 1", reg_out, busy);
    end
    jump_addr = 7'd1; condition = 2'b00;
    #1;
    checks++;
    if (ops_valid !== 1'b1) begin
      errors++;
      $display("FAIL run_ops_valid: got %b, want 1", ops_valid);
    end
    tick();
    checks++;
    if (reg_out !== 16'd1) begin
      errors++;
      $display("FAIL jump_uncond: got reg_out=%0d, want 1", reg_out);
    end
    $display("test_start_jump done");
  endtask

  task automatic test_dispatch();
    jump_addr = 7'd2; condition = 2'b00;
    tick();
    bt = 1; opcode = 7'd27; condition = 2'b11;
    #1;
    checks++;
    if (reg_out !== 16'd2 || ops_valid !== 1'b1) begin
      errors++;
      $display("FAIL dispatch_pre: got reg_out=%0d ov=%b, want 2 and 1", reg_out, ops_valid);
    end
    tick();
    bt = 0; condition = 2'b00;
    checks++;
    if (reg_out !== 16'd27 || halted !== 1'b0 || ops_valid !== 1'b1) begin
      errors++;
      $display("FAIL dispatch: got reg_out=%0d halted=%b ov=%b, want 27 0 1", reg_out, halted, ops_valid);
    end
    start = 1; jump_addr = 7'd5;
    tick();
    start = 0;
    checks++;
    if (reg_out !== 16'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_run: got reg_out=%0d busy=%b, want 5 1", reg_out, busy);
    end
    $display("test_dispatch done");
  endtask

  task automatic test_conditional();
    condition = 2'b00; jump_addr = 7'd66;
    tick();
    condition = 2'b01; jump_addr = 7'd69; z_flag = 1;
    tick();
    checks++;
    if (reg_out !== 16'd69) begin
      errors++;
      $display("FAIL cond01_taken: got reg_out=%0d, want 69", reg_out);
    end
    condition = 2'b00; jump_addr = 7'd66;
    tick();
    condition = 2'b01; jump_addr = 7'd69; z_flag = 0;
    tick();
    checks++;
    if (reg_out !== 16'd67) begin
      errors++;
      $display("FAIL cond01_fall: got reg_out=%0d, want 67", reg_out);
    end
    condition = 2'b10; jump_addr = 7'd3; z_flag = 0;
    tick();
    checks++;
    if (reg_out !== 16'd3) begin
      errors++;
      $display("FAIL cond10_taken: got reg_out=%0d, want 3", reg_out);
    end
    z_flag = 1;
    tick();
    checks++;
    if (reg_out !== 16'd4) begin
      errors++;
      $display("FAIL cond10_fall: got reg_out=%0d, want 4", reg_out);
    end
    z_flag = 0;
    $display("test_conditional done");
  endtask

  task automatic test_stall();
    condition = 2'b00; jump_addr = 7'd12;
    tick();
    stall = 1; condition = 2'b01; jump_addr = 7'd40; z_flag = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (reg_out !== 16'd12 || ops_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got reg_out=%0d ov=%b, want 12 0", i, reg_out, ops_valid);
      end
    end
    stall = 0;
    #1;
    checks++;
    if (ops_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ov: got %b, want 1", ops_valid);
    end
    tick();
    checks++;
    if (reg_out !== 16'd13) begin
      errors++;
      $display("FAIL stall_release: got reg_out=%0d, want 13", reg_out);
    end
    $display("test_stall done");
  endtask

  task automatic test_stall_halt();
    condition = 2'b11; stall = 1;
    tick();
    checks++;
    if (halted !== 1'b0 || reg_out !== 16'd13 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_over_halt: got halted=%b reg_out=%0d busy=%b, want 0 13 1", halted, reg_out, busy);
    end
    stall = 0;
    tick();
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || fault !== 1'b0 || reg_out !== 16'd13 || ops_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt: got halted=%b busy=%b fault=%b reg_out=%0d ov=%b, want 1 0 0 13 0",
               halted, busy, fault, reg_out, ops_valid);
    end
    condition = 2'b00;
    $display("test_stall_halt done");
  endtask

  task automatic test_fault();
    do_reset();
    do_start();
    bt = 1; opcode = 7'd100;
    tick();
    bt = 0;
    checks++;
    if (halted !== 1'b1 || fault !== 1'b1 || reg_out !== 16'd0) begin
      errors++;
      $display("FAIL fault_dispatch: got halted=%b fault=%b reg_out=%0d, want 1 1 0", halted, fault, reg_out);
    end
    do_start();
    tick();
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || fault !== 1'b1) begin
      errors++;
      $display("FAIL halt_ignores_start: got halted=%b busy=%b fault=%b, want 1 0 1", halted, busy, fault);
    end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if ({reg_out, ops_valid, busy, halted, fault} !== 20'h0) begin
      errors++;
      $display("FAIL fault_reset: got reg_out=%0d ov=%b busy=%b halted=%b fault=%b, want all 0",
               reg_out, ops_valid, busy, halted, fault);
    end
    $display("test_fault done");
  endtask

  task automatic test_boundary();
    do_start();
    condition = 2'b00; jump_addr = 7'd74;
    tick();
    checks++;
    if (reg_out !== 16'd74 || halted !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL last_addr_ok: got reg_out=%0d halted=%b fault=%b, want 74 0 0", reg_out, halted, fault);
    end
    condition = 2'b01; z_flag = 0;
    tick();
    checks++;
    if (reg_out !== 16'd74 || halted !== 1'b1 || fault !== 1'b1) begin
      errors++;
      $display("FAIL inc_past_last: got reg_out=%0d halted=%b fault=%b, want 74 1 1", reg_out, halted, fault);
    end
    $display("test_boundary done");
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    do_start();
    condition = 2'b00; jump_addr = 7'd30;
    tick();
    stall = 1; reset = 1;
    tick();
    checks++;
    if (reg_out !== 16'd0 || busy !== 1'b0 || halted !== 1'b0 || fault !== 1'b0 || ops_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got reg_out=%0d busy=%b halted=%b fault=%b ov=%b, want 0 0 0 0 0",
               reg_out, busy, halted, fault, ops_valid);
    end
    reset = 0; stall = 0;
    $display("test_reset_mid_run done");
  endtask

  initial begin
    test_reset();
    test_start_jump();
    test_dispatch();
    test_conditional();
    test_stall();
    test_stall_halt();
    test_fault();
    test_boundary();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
